// File: rtl/instruction_store_if.sv
// Host load stream and core fetch port of the instruction store.
// master = host/core side, slave = the store itself.
interface instruction_store_if #(
    parameter int ADDR_W = 8
);
    logic              startLoad;
    logic              loadValid;
    logic              loadReady;
    logic [7:0]        loadByte;
    logic              loadLast;
    logic              loadError;
    logic              running;
    logic [ADDR_W:0]   programLength;
    logic [16:0]       instructionPointer;
    logic [25:0]       instruction;
    logic              instructionValid;
    logic              fetchFault;

    modport master (
        output startLoad, loadValid, loadByte, loadLast, instructionPointer,
        input  loadReady, loadError, running, programLength,
               instruction, instructionValid, fetchFault
    );

    modport slave (
        input  startLoad, loadValid, loadByte, loadLast, instructionPointer,
        output loadReady, loadError, running, programLength,
               instruction, instructionValid, fetchFault
    );
endinterface

// File: rtl/instruction_store.sv
// Program memory: packs a little-endian byte stream into 26-bit words, then
// serves registered instruction fetches bounded by the loaded program length.
module instruction_store #(
    parameter int ADDR_W = 8
) (
    input  logic               clock,
    input  logic               resetN,
    instruction_store_if.slave bus
);
    localparam int              DEPTH    = 2**ADDR_W;
    localparam logic [ADDR_W:0] FULL_LEN = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [ADDR_W-1:0] r_wrPtr;
    logic [1:0]        r_byteIdx;
    logic [ADDR_W:0]   r_progLen;
    logic              r_loadError;
    logic [23:0]       r_partial;
    logic [25:0]       r_mem [DEPTH];
    logic [25:0]       r_instr_p1;
    logic              r_vld_p1;
    logic              r_fault_p1;

    logic              w_xfer;
    logic              w_full;
    logic              w_wordDone;
    logic              w_badHigh;
    logic              w_inRange;
    logic              w_fetchEn;
    logic [25:0]       w_word;

    // startLoad wins over a byte offered in the same cycle
    assign w_xfer     = bus.loadValid && (r_state == S_LOAD) && !bus.startLoad;
    assign w_full     = (r_progLen == FULL_LEN);
    assign w_wordDone = w_xfer && (r_byteIdx == 2'd3);
    assign w_badHigh  = (bus.loadByte[7:2] != 6'd0);
    assign w_word     = {bus.loadByte[1:0], r_partial};
    assign w_inRange  = (bus.instructionPointer < 17'(r_progLen));
    assign w_fetchEn  = (r_state == S_RUN) && !bus.startLoad;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) r_state <= S_IDLE;
        else         r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        if (bus.startLoad)                w_nextState = S_LOAD;
        else if (w_xfer && bus.loadLast)  w_nextState = S_RUN;
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_wrPtr     <= '0;
            r_byteIdx   <= 2'd0;
            r_progLen   <= '0;
            r_loadError <= 1'b0;
        end else if (bus.startLoad) begin
            r_wrPtr     <= '0;
            r_byteIdx   <= 2'd0;
            r_progLen   <= '0;
            r_loadError <= 1'b0;
        end else if (w_xfer) begin
            r_byteIdx <= r_byteIdx + 2'd1;
            // once storage is full the host keeps draining into nowhere
            if (w_full) r_loadError <= 1'b1;
            if (r_byteIdx == 2'd3) begin
                if (w_badHigh) r_loadError <= 1'b1;
                if (!w_full) begin
                    r_wrPtr   <= r_wrPtr + 1'b1;
                    r_progLen <= r_progLen + 1'b1;
                end
            end else if (bus.loadLast) begin
                r_loadError <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_xfer) begin
            case (r_byteIdx)
                2'd0:    r_partial[7:0]   <= bus.loadByte;
                2'd1:    r_partial[15:8]  <= bus.loadByte;
                2'd2:    r_partial[23:16] <= bus.loadByte;
                default: ;
            endcase
        end
    end

    // storage is deliberately not reset; contents outlive reset and reloads
    always_ff @(posedge clock) begin
        if (w_wordDone && !w_full) r_mem[r_wrPtr] <= w_word;
    end

    // ---- fetch stage: address in, registered word out ----
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_instr_p1 <= '0;
            r_vld_p1   <= 1'b0;
            r_fault_p1 <= 1'b0;
        end else if (w_fetchEn && w_inRange) begin
            r_instr_p1 <= r_mem[bus.instructionPointer[ADDR_W-1:0]];
            r_vld_p1   <= 1'b1;
            r_fault_p1 <= 1'b0;
        end else begin
            r_instr_p1 <= '0;
            r_vld_p1   <= 1'b0;
            r_fault_p1 <= w_fetchEn;
        end
    end

    assign bus.loadReady        = (r_state == S_LOAD);
    assign bus.running          = (r_state == S_RUN);
    assign bus.loadError        = r_loadError;
    assign bus.programLength    = r_progLen;
    assign bus.instruction      = r_instr_p1;
    assign bus.instructionValid = r_vld_p1;
    assign bus.fetchFault       = r_fault_p1;
endmodule

// File: tb/tb_instruction_store.sv
// Scoreboard bench for instruction_store: a byte-list program model predicts
// every cycle's outputs; a monitor pops and compares on each falling edge.
module tb_instruction_store;
    localparam int ADDR_W = 2;
    localparam int DEPTH  = 2**ADDR_W;

    typedef struct {
        logic            ready;
        logic            err;
        logic            run;
        logic [ADDR_W:0] len;
        logic [25:0]     ins;
        logic            iv;
        logic            ff;
    } exp_t;

    logic clk = 1'b0;
    logic resetN = 1'b1;
    always #5 clk = ~clk;

    instruction_store_if #(.ADDR_W(ADDR_W)) bus ();

    instruction_store #(.ADDR_W(ADDR_W)) dut (
        .clock  (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    event chk_now;

    // reference model: 0 idle, 1 loading, 2 running
    int          m_mode = 0;
    int          m_len  = 0;
    bit          m_err  = 0;
    logic [7:0]  m_pend[$];
    logic [25:0] m_mem [DEPTH];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endfunction

    always begin
        @(negedge clk or chk_now);
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("loadReady",        32'(bus.loadReady),        32'(mon_e.ready));
            chk("loadError",        32'(bus.loadError),        32'(mon_e.err));
            chk("running",          32'(bus.running),          32'(mon_e.run));
            chk("programLength",    32'(bus.programLength),    32'(mon_e.len));
            chk("instruction",      32'(bus.instruction),      32'(mon_e.ins));
            chk("instructionValid", 32'(bus.instructionValid), 32'(mon_e.iv));
            chk("fetchFault",       32'(bus.fetchFault),       32'(mon_e.ff));
        end
    end

    task automatic model_step(input bit st, input bit v, input logic [7:0] b,
                              input bit l, input logic [16:0] ip);
        exp_t e;
        e.ins = '0; e.iv = 1'b0; e.ff = 1'b0;
        if (m_mode == 2 && !st) begin
            if (int'(ip) < m_len) begin
                e.ins = m_mem[ip[ADDR_W-1:0]];
                e.iv  = 1'b1;
            end else begin
                e.ff = 1'b1;
            end
        end
        if (st) begin
            m_mode = 1; m_len = 0; m_err = 0; m_pend.delete();
        end else if (m_mode == 1 && v) begin
            if (m_len == DEPTH) m_err = 1;
            m_pend.push_back(b);
            if (m_pend.size() == 4) begin
                if (m_pend[3] > 8'd3) m_err = 1;
                if (m_len < DEPTH) begin
                    m_mem[m_len] = {m_pend[3][1:0], m_pend[2], m_pend[1], m_pend[0]};
                    m_len++;
                end
                m_pend.delete();
            end
            if (l) begin
                if (m_pend.size() != 0) m_err = 1;
                m_mode = 2;
            end
        end
        e.ready = (m_mode == 1);
        e.run   = (m_mode == 2);
        e.err   = m_err;
        e.len   = m_len[ADDR_W:0];
        exp_q.push_back(e);
    endtask

    task automatic cycle(input bit st, input bit v, input logic [7:0] b,
                         input bit l, input logic [16:0] ip);
        @(negedge clk);
        #1;
        bus.startLoad = st; bus.loadValid = v; bus.loadByte = b;
        bus.loadLast = l; bus.instructionPointer = ip;
        model_step(st, v, b, l, ip);
    endtask

    task automatic do_reset();
        exp_t e;
        @(negedge clk);
        #1;
        bus.startLoad = 0; bus.loadValid = 0; bus.loadByte = 0;
        bus.loadLast = 0; bus.instructionPointer = 0;
        resetN = 1'b0;
        #1;
        m_mode = 0; m_len = 0; m_err = 0; m_pend.delete();
        e.ready = 0; e.err = 0; e.run = 0; e.len = '0; e.ins = '0; e.iv = 0; e.ff = 0;
        exp_q.push_back(e);
        -> chk_now;
        @(negedge clk);
        #1;
        resetN = 1'b1;
    endtask

    task automatic send_bytes(input logic [7:0] bytes[$]);
        for (int i = 0; i < bytes.size(); i++)
            cycle(0, 1, bytes[i], i == bytes.size() - 1, 17'd0);
    endtask

    initial begin
        logic [7:0] bq[$];
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        bus.startLoad = 0; bus.loadValid = 0; bus.loadByte = 0;
        bus.loadLast = 0; bus.instructionPointer = 0;
        do_reset();

        // basic load and fetch
        cycle(1, 0, 8'h00, 0, 17'd0);
        bq = '{8'h78, 8'h56, 8'h34, 8'h01, 8'hEF, 8'hCD, 8'hAB, 8'h02};
        send_bytes(bq);
        cycle(0, 0, 8'h00, 0, 17'd0);
        cycle(0, 0, 8'h00, 0, 17'd1);
        chk("t1_word0", 32'(bus.instruction), 32'h1345678);
        chk("t1_len", 32'(bus.programLength), 32'd2);
        cycle(0, 0, 8'h00, 0, 17'd2);
        chk("t1_word1", 32'(bus.instruction), 32'h2ABCDEF);
        cycle(0, 0, 8'h00, 0, 17'd0);
        chk("t1_fault", 32'(bus.fetchFault), 32'd1);

        // illegal high bits in byte 3
        cycle(1, 0, 8'h00, 0, 17'd0);
        bq = '{8'h11, 8'h22, 8'h33, 8'hFD};
        send_bytes(bq);
        cycle(0, 0, 8'h00, 0, 17'd0);
        cycle(0, 0, 8'h00, 0, 17'd0);
        chk("t2_word", 32'(bus.instruction), 32'h1332211);
        chk("t2_err", 32'(bus.loadError), 32'd1);

        // partial final word
        cycle(1, 0, 8'h00, 0, 17'd0);
        bq = '{8'h01, 8'h02, 8'h03, 8'h00, 8'h05, 8'h06};
        send_bytes(bq);
        cycle(0, 0, 8'h00, 0, 17'd1);
        chk("t3_len", 32'(bus.programLength), 32'd1);

        // overflow: five words into four slots
        cycle(1, 0, 8'h00, 0, 17'd0);
        bq.delete();
        for (int k = 0; k < 5; k++) begin
            bq.push_back(8'(8'h10 + k)); bq.push_back(8'h20);
            bq.push_back(8'h30);         bq.push_back(8'h01);
        end
        send_bytes(bq);
        for (int k = 0; k < 5; k++) cycle(0, 0, 8'h00, 0, 17'(k));
        cycle(0, 0, 8'h00, 0, 17'h10000);
        cycle(0, 0, 8'h00, 0, 17'd0);
        cycle(0, 0, 8'h00, 0, 17'd0);
        chk("t4_word0", 32'(bus.instruction), 32'h1302010);
        chk("t4_len", 32'(bus.programLength), 32'd4);

        // restart collides with an offered byte while running
        cycle(1, 1, 8'hAA, 0, 17'd0);
        cycle(0, 0, 8'h00, 0, 17'd0);
        chk("t5_valid", 32'(bus.instructionValid), 32'd0);
        bq = '{8'h01, 8'h02, 8'h03, 8'h00};
        send_bytes(bq);
        cycle(0, 0, 8'h00, 0, 17'd0);
        cycle(0, 0, 8'h00, 0, 17'd0);
        chk("t5_word", 32'(bus.instruction), 32'h0030201);

        // asynchronous reset in the middle of a load
        cycle(1, 0, 8'h00, 0, 17'd0);
        cycle(0, 1, 8'h44, 0, 17'd0);
        cycle(0, 1, 8'h55, 0, 17'd0);
        do_reset();
        cycle(0, 1, 8'h66, 1, 17'd0);

        // randomized loads, fetches, collisions and resets
        for (int it = 0; it < 40; it++) begin
            int nb;
            cycle(1, $urandom_range(0, 1), 8'($urandom), 0, 17'd0);
            nb = $urandom_range(0, 22);
            for (int i = 0; i < nb; i++) begin
                logic [7:0] b;
                while ($urandom_range(0, 3) == 0)
                    cycle(0, 0, 8'($urandom), $urandom_range(0, 1), 17'($urandom_range(0, 5)));
                b = 8'($urandom);
                if (i % 4 == 3 && $urandom_range(0, 3) != 0) b = b & 8'h03;
                if ($urandom_range(0, 29) == 0)
                    cycle(1, 1, b, 0, 17'd0);
                else
                    cycle(0, 1, b, i == nb - 1, 17'($urandom_range(0, 5)));
            end
            if ($urandom_range(0, 9) == 0) do_reset();
            for (int f = 0; f < 8; f++) begin
                logic [16:0] ip;
                ip = ($urandom_range(0, 5) == 0) ? 17'($urandom) : 17'($urandom_range(0, 5));
                cycle(0, $urandom_range(0, 1), 8'($urandom), 0, ip);
            end
        end

        cycle(0, 0, 8'h00, 0, 17'd0);
        @(negedge clk);
        #2;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
